// File: rtl/uart_frame_sched_if.sv
// Request/measurement inputs and uart_tx handshake for uart_frame_sched.
// master = requesters + uart_tx side, slave = the scheduler.
interface uart_frame_sched_if;
    logic       req_agua;
    logic       req_peso;
    logic [3:0] val_agua;
    logic [3:0] val_peso;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] gnt;
    logic       busy;
    logic       frame_done;

    modport master (
        output req_agua, req_peso, val_agua, val_peso, tx_ready,
        input  tx_start, tx_data, gnt, busy, frame_done
    );

    modport slave (
        input  req_agua, req_peso, val_agua, val_peso, tx_ready,
        output tx_start, tx_data, gnt, busy, frame_done
    );
endinterface

// File: rtl/uart_frame_sched.sv
// Round-robin frame scheduler: arbitrates water/weight requests and feeds uart_tx
// one ASCII frame per grant. Define CHECKSUM_EN to insert an ID^digit byte before EOF.
module uart_frame_sched #(
    parameter logic [7:0] SOF_BYTE = 8'h7B,
    parameter logic [7:0] EOF_BYTE = 8'h7D,
    parameter logic [7:0] ID_AGUA  = 8'h41,
    parameter logic [7:0] ID_PESO  = 8'h50
) (
    input  logic               clk,
    input  logic               rstn,
    uart_frame_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

`ifdef CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] val_q, val_d;
    logic       sel_q, sel_d;     // requester of current/last frame: 1 = peso
    logic       done_q, done_d;

    logic       pick_agua, pick_peso;
    logic [7:0] id_byte, digit_byte, frame_byte;

    // sel_q doubles as the round-robin pointer; reset value 1 makes agua win first.
    assign pick_agua = bus.req_agua & (~bus.req_peso | sel_q);
    assign pick_peso = bus.req_peso & (~bus.req_agua | ~sel_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            val_q   <= 4'd0;
            sel_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_agua) begin
                    sel_d   = 1'b0;
                    val_d   = bus.val_agua;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end else if (pick_peso) begin
                    sel_d   = 1'b1;
                    val_d   = bus.val_peso;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame bytes come only from latched registers, so they hold steady in SEND.
    always_comb begin
        id_byte    = sel_q ? ID_PESO : ID_AGUA;
        digit_byte = (val_q < 4'd10) ? (8'h30 + {4'h0, val_q}) : (8'h37 + {4'h0, val_q});
        case (idx_q)
            3'd0:    frame_byte = SOF_BYTE;
            3'd1:    frame_byte = id_byte;
            3'd2:    frame_byte = digit_byte;
`ifdef CHECKSUM_EN
            3'd3:    frame_byte = id_byte ^ digit_byte;
`endif
            default: frame_byte = EOF_BYTE;
        endcase
    end

    always_comb begin
        bus.tx_start   = (state_q == SEND);
        bus.tx_data    = (state_q == SEND) ? frame_byte : 8'h00;
        bus.busy       = (state_q != IDLE);
        bus.gnt        = (state_q == IDLE) ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
        bus.frame_done = done_q;
    end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched with a simple uart_tx ready model.
module tb_uart_frame_sched;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    uart_frame_sched_if mif();

    uart_frame_sched dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (mif.slave)
    );

`ifdef CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    int checks   = 0;
    int failures = 0;
    int hold_len = 10;
    int done_cnt = 0;
    int d0;
    logic [7:0] cap[$];
    logic [1:0] gcap[$];
    logic [7:0] exp_b[$];
    logic [1:0] exp_g[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx model: ready drops after each accepted byte for hold_len cycles.
    initial begin
        mif.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mif.tx_start === 1'b1 && mif.tx_ready === 1'b1) begin
                cap.push_back(mif.tx_data);
                gcap.push_back(mif.gnt);
                @(posedge clk);
                #1 mif.tx_ready = 1'b0;
                repeat (hold_len) @(posedge clk);
                #1 mif.tx_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mif.frame_done === 1'b1) begin
            done_cnt++;
            chk("busy_at_done", {31'b0, mif.busy}, 32'd0);
        end
    end

    task automatic add_frame(input logic [7:0] id, input logic [7:0] dig,
                             input logic [7:0] ck, input logic [1:0] g);
        exp_b.push_back(8'h7B);
        exp_b.push_back(id);
        exp_b.push_back(dig);
`ifdef CHECKSUM_EN
        exp_b.push_back(ck);
`endif
        exp_b.push_back(8'h7D);
        for (int i = 0; i < NB; i++) exp_g.push_back(g);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_len"}, cap.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < cap.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), {24'b0, cap[i]}, {24'b0, exp_b[i]});
            chk($sformatf("%s_g%0d", tag, i), {30'b0, gcap[i]}, {30'b0, exp_g[i]});
        end
        cap.delete(); gcap.delete(); exp_b.delete(); exp_g.delete();
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (mif.busy !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk("busy_wait", {31'b0, mif.busy}, 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
        chk("done_wait", done_cnt, target);
    endtask

    task automatic wait_cap(input int sz, input int budget);
        int n = 0;
        while (cap.size() < sz && n < budget) begin @(negedge clk); n++; end
        chk("cap_wait", cap.size(), sz);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_start"}, {31'b0, mif.tx_start},   32'd0);
        chk({tag, "_data"},  {24'b0, mif.tx_data},    32'd0);
        chk({tag, "_gnt"},   {30'b0, mif.gnt},        32'd0);
        chk({tag, "_busy"},  {31'b0, mif.busy},       32'd0);
        chk({tag, "_done"},  {31'b0, mif.frame_done}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        mif.req_agua = 1'b0; mif.req_peso = 1'b0;
        mif.val_agua = 4'h0; mif.val_peso = 4'h0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("idle_noreq");

        // single agua frame, value 7
        mif.val_agua = 4'h7; mif.req_agua = 1'b1;
        wait_busy(5);
        mif.req_agua = 1'b0;
        wait_done(1, 400);
        repeat (3) @(negedge clk);
        chk("agua7_done_cnt", done_cnt, 1);
        add_frame(8'h41, 8'h37, 8'h76, 2'b01);
        chk_frame("agua7");
        chk("after_gnt", {30'b0, mif.gnt}, 32'd0);

        // both held from reset: agua, peso, agua
        rstn = 1'b0; @(negedge clk); rstn = 1'b1;
        mif.val_agua = 4'h1; mif.val_peso = 4'hC;
        mif.req_agua = 1'b1; mif.req_peso = 1'b1;
        wait_done(3, 1000);
        wait_busy(5);
        mif.req_agua = 1'b0; mif.req_peso = 1'b0;
        wait_done(4, 400);
        repeat (3) @(negedge clk);
        add_frame(8'h41, 8'h31, 8'h70, 2'b01);
        add_frame(8'h50, 8'h43, 8'h13, 2'b10);
        add_frame(8'h41, 8'h31, 8'h70, 2'b01);
        chk_frame("rr");

        // value change mid-frame must not leak into the digit
        mif.val_agua = 4'h2; mif.req_agua = 1'b1;
        wait_busy(5);
        wait_cap(1, 50);
        mif.val_agua = 4'h9; mif.req_agua = 1'b0;
        wait_done(5, 400);
        repeat (3) @(negedge clk);
        add_frame(8'h41, 8'h32, 8'h73, 2'b01);
        chk_frame("latch");

        // reset during WAIT_BUSY of byte index 2
        mif.val_agua = 4'h5; mif.req_agua = 1'b1;
        wait_busy(5);
        mif.req_agua = 1'b0;
        wait_cap(3, 200);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk_idle_outputs("midrst");
        @(negedge clk); rstn = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_no_start", cap.size(), 3);
        chk("midrst_no_done", done_cnt, 5);
        exp_b = '{8'h7B, 8'h41, 8'h35};
        exp_g = '{2'b01, 2'b01, 2'b01};
        chk_frame("partial");
        mif.req_agua = 1'b1;
        wait_busy(5);
        mif.req_agua = 1'b0;
        wait_done(6, 400);
        repeat (3) @(negedge clk);
        add_frame(8'h41, 8'h35, 8'h74, 2'b01);
        chk_frame("restart");

        // long WAIT_DONE stall on the first byte
        hold_len = 1000;
        mif.val_peso = 4'hF; mif.req_peso = 1'b1;
        wait_busy(5);
        mif.req_peso = 1'b0;
        wait_cap(1, 50);
        hold_len = 10;
        repeat (500) @(negedge clk);
        chk("stall_start", {31'b0, mif.tx_start}, 32'd0);
        chk("stall_busy",  {31'b0, mif.busy},     32'd1);
        chk("stall_gnt",   {30'b0, mif.gnt},      32'd2);
        chk("stall_cap",   cap.size(),            1);
        wait_done(7, 2000);
        repeat (3) @(negedge clk);
        add_frame(8'h50, 8'h46, 8'h16, 2'b10);
        chk_frame("stall");

        // single peso frame, value 3 (checksum 63 when enabled)
        mif.val_peso = 4'h3; mif.req_peso = 1'b1;
        wait_busy(5);
        mif.req_peso = 1'b0;
        d0 = done_cnt;
        wait_done(d0 + 1, 400);
        repeat (3) @(negedge clk);
        add_frame(8'h50, 8'h33, 8'h63, 2'b10);
        chk_frame("peso3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_sched.md
UART_FRAME_SCHED -- requirements
Module: uart_frame_sched

Interface
REQ-001 Parameter SOF_BYTE, default 8'h7B, is the frame start byte ('{').
REQ-002 Parameter EOF_BYTE, default 8'h7D, is the frame end byte ('}').
REQ-003 Parameter ID_AGUA, default 8'h41, is the water requester ID byte ('A').
REQ-004 Parameter ID_PESO, default 8'h50, is the food/weight requester ID byte ('P').
REQ-005 clk  in  1  is the single system clock; all state SHALL update on its rising edge.
REQ-006 rstn  in  1  is the reset: asynchronous, active-low.
REQ-007 req_agua  in  1  is the level request from the water channel.
REQ-008 req_peso  in  1  is the level request from the weight channel.
REQ-009 val_agua  in  4  is the water measurement.
REQ-010 val_peso  in  4  is the weight measurement.
REQ-011 tx_ready  in  1  is the uart_tx ready flag: 1 = idle, 0 = shifting.
REQ-012 tx_start  out  1  is the uart_tx start strobe.
REQ-013 tx_data  out  8  is the byte presented to uart_tx.
REQ-014 gnt  out  2  is the one-hot grant: bit0 = agua, bit1 = peso.
REQ-015 busy  out  1  is high while a frame is in progress.
REQ-016 frame_done  out  1  is a one-cycle pulse after the last byte completes.

Function
REQ-017 The FSM SHALL have states IDLE, SEND, WAIT_BUSY and WAIT_DONE, plus a byte index register idx.
REQ-018 IDLE: with no request, the FSM SHALL stay in IDLE with gnt=0 and busy=0.
- With exactly one request, it SHALL grant that requester.
- With both requests, it SHALL grant the requester not served last (round-robin).
- On grant it SHALL latch the value (4 bits), set gnt, set idx=0 and go to SEND.
REQ-019 After reset, agua SHALL win the first simultaneous request.
REQ-020 The frame SHALL be: SOF_BYTE, ID byte, ASCII hex digit of the latched value, EOF_BYTE (4 bytes).
- Digit = 8'h30+v for v 0..9; 8'h37+v for v 10..15 ('A'..'F').
REQ-021 SEND: tx_data = byte[idx]; tx_start=1.
- On the cycle with tx_start=1 and tx_ready=1, the byte is accepted and the FSM SHALL move to WAIT_BUSY.
REQ-022 WAIT_BUSY: tx_start=0; the FSM SHALL move to WAIT_DONE when tx_ready=0.
REQ-023 WAIT_DONE: the FSM SHALL wait for tx_ready=1.
- If idx is the last index, it SHALL pulse frame_done, clear gnt and return to IDLE.
- Otherwise it SHALL increment idx and return to SEND.
REQ-024 tx_data SHALL be stable for the whole SEND state.
REQ-025 Exactly one tx_start acceptance SHALL occur per byte.
REQ-026 Request or value changes during a frame SHALL NOT alter the frame in progress.
REQ-027 A request held through a frame SHALL be re-arbitrated in IDLE; at least one IDLE cycle SHALL separate frames.
REQ-028 A request deasserted before grant SHALL be dropped; requests are not queued.
REQ-029 busy SHALL be 1 in SEND, WAIT_BUSY and WAIT_DONE.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-031 On rstn=0, the block SHALL immediately and asynchronously enter:
- state IDLE, idx=0, latched value 0;
- round-robin pointer set so that agua is preferred;
- tx_start=0, tx_data=8'h00, gnt=2'b00, busy=0, frame_done=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further tx_start until a new grant.

Configuration
REQ-033 When CHECKSUM_EN is defined, a checksum byte (ID byte XOR digit byte) SHALL be inserted before EOF_BYTE, giving a 5-byte frame with last index 4.
REQ-034 When CHECKSUM_EN is undefined, the frame SHALL be 4 bytes with last index 3, and no checksum logic is present.

Verification
REQ-035 req_agua=1, val_agua=4'h7, uart model (ready low 10 cycles per byte) -> bytes 7B,41,37,7D in order; one frame_done pulse; gnt=01 throughout.
REQ-036 req_agua=req_peso=1 held, val_peso=4'hC -> frames alternate agua, peso, agua; peso frame is 7B,50,43,7D.
REQ-037 CHECKSUM_EN defined, req_peso=1, val_peso=4'h3 -> bytes 7B,50,33,63,7D.
REQ-038 val_agua changes 4'h2 to 4'h9 after grant, mid-frame -> the digit byte sent is 32.
REQ-039 rstn pulsed low during WAIT_BUSY of byte 2 -> outputs reset immediately; no tx_start until a request; the next frame restarts at SOF.
REQ-040 tx_ready held 0 for 1000 cycles in WAIT_DONE -> FSM stays in WAIT_DONE, tx_start=0, busy=1, no idx advance.
